// File: rtl/tile_pkg.sv
// Shared types and helpers for the brute-force Sudoku cell.
//   state_t    : one-hot FSM state encoding (7 states)
//   tile_len   : number of values per row for a given sub-grid order
//   is_onehot  : true when exactly one bit is set
package tile_pkg;

    typedef enum logic [6:0] {
        ST_RESET    = 7'b000_0001,
        ST_WAITING  = 7'b000_0010,
        ST_INCRIDX  = 7'b000_0100,
        ST_REQUEST  = 7'b000_1000,
        ST_AWAITRSP = 7'b001_0000,
        ST_PASSFWD  = 7'b010_0000,
        ST_PASSBAK  = 7'b100_0000
    } state_t;

    function automatic int unsigned tile_len(input int unsigned grid_order);
        return grid_order * grid_order;
    endfunction

    function automatic logic is_onehot(input logic [63:0] v);
        return $onehot(v);
    endfunction

endpackage

// File: rtl/tile_index_ring.sv
// One-hot rotating candidate index, N+1 bits; bit N means exhausted/empty.
//   clock, reset : system clock, synchronous active-high reset (to empty)
//   clear        : force the index back to empty
//   rotate       : shift up by one, bit N wraps to bit 0
//   cand_next_c  : candidate bits of the index value after this cycle
//   exhausted_c  : empty bit of the index value after this cycle
module tile_index_ring #(
    parameter int unsigned N = 9
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         clear,
    input  logic         rotate,
    output logic [N-1:0] cand_next_c,
    output logic         exhausted_c
);

    localparam logic [N:0] EMPTY = {1'b1, {N{1'b0}}};

    logic [N:0] idx_q;
    logic [N:0] idx_d;

    // Next index: clear wins over rotate.
    always_comb begin
        idx_d = idx_q;
        if (clear) begin
            idx_d = EMPTY;
        end else if (rotate) begin
            idx_d = {idx_q[N-1:0], idx_q[N]};
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            idx_q <= EMPTY;
        end else begin
            idx_q <= idx_d;
        end
    end

    // Look-ahead lets the FSM decide on the freshly rotated index in one cycle.
    assign cand_next_c = idx_d[N-1:0];
    assign exhausted_c = idx_d[N];

endmodule

// File: rtl/tile_cell.sv
// Brute-force Sudoku cell: walks candidate bias indices, asks the shared bias
// module for a value, accepts it if no peer uses it, and passes the control
// token forward on success or backward on exhaustion. Supports clue cells.
//   clock, reset           : system clock, synchronous active-high reset
//   myturn, fromfwd        : token arrival and its direction (1 = backtrack)
//   passfwd, passbak       : one-cycle token hand-off pulses
//   given_load, given_val  : clue load (one-hot, zero clears the clue)
//   rq_valid, rq_ready     : bias request handshake, biasidx one-hot index
//   rsp_valid, valtotry    : bias reply, valcannotbe peer-used value mask
//   value, locked          : cell value (one-hot, 0 = empty), clue flag
//   trycount               : saturating count of consumed bias replies
module tile_cell
    import tile_pkg::*;
#(
    parameter  int unsigned GRID_ORDER = 3,
    parameter  int unsigned TRY_W      = 16,
    localparam int unsigned LEN        = tile_len(GRID_ORDER)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             myturn,
    input  logic             fromfwd,
    output logic             passfwd,
    output logic             passbak,
    input  logic             given_load,
    input  logic [LEN-1:0]   given_val,
    output logic             rq_valid,
    input  logic             rq_ready,
    output logic [LEN-1:0]   biasidx,
    input  logic             rsp_valid,
    input  logic [LEN-1:0]   valtotry,
    input  logic [LEN-1:0]   valcannotbe,
    output logic [LEN-1:0]   value,
    output logic             locked,
    output logic [TRY_W-1:0] trycount
);

    state_t           state_q,    state_d;
    logic [LEN-1:0]   value_q,    value_d;
    logic             locked_q,   locked_d;
    logic [TRY_W-1:0] trycount_q, trycount_d;
    logic             passfwd_q,  passfwd_d;
    logic             passbak_q,  passbak_d;
    logic             rq_valid_q, rq_valid_d;
    logic [LEN-1:0]   biasidx_q,  biasidx_d;

    logic             ring_clear;
    logic             ring_rotate;
    logic [LEN-1:0]   cand_next_c;
    logic             exhausted_c;

    tile_index_ring #(
        .N (LEN)
    ) u_ring (
        .clock       (clock),
        .reset       (reset),
        .clear       (ring_clear),
        .rotate      (ring_rotate),
        .cand_next_c (cand_next_c),
        .exhausted_c (exhausted_c)
    );

    // Next-state, datapath and Moore output decode.
    always_comb begin
        state_d     = state_q;
        value_d     = value_q;
        locked_d    = locked_q;
        trycount_d  = trycount_q;
        ring_clear  = 1'b0;
        ring_rotate = 1'b0;

        case (state_q)
            ST_RESET: begin
                state_d = ST_WAITING;
            end
            ST_WAITING: begin
                if (given_load) begin
                    if (given_val != '0) begin
                        value_d  = given_val;
                        locked_d = 1'b1;
                    end else begin
                        value_d    = '0;
                        locked_d   = 1'b0;
                        ring_clear = 1'b1;
                    end
                end else if (myturn) begin
                    if (locked_q) begin
                        state_d = fromfwd ? ST_PASSBAK : ST_PASSFWD;
                    end else begin
                        state_d = ST_INCRIDX;
                    end
                end
            end
            ST_INCRIDX: begin
                ring_rotate = 1'b1;
                state_d     = exhausted_c ? ST_PASSBAK : ST_REQUEST;
            end
            ST_REQUEST: begin
                if (rq_ready) begin
                    state_d = ST_AWAITRSP;
                end
            end
            ST_AWAITRSP: begin
                if (rsp_valid) begin
                    if (trycount_q != '1) begin
                        trycount_d = trycount_q + TRY_W'(1);
                    end
                    if ((valtotry == '0) || ((valtotry & valcannotbe) != '0)) begin
                        state_d = ST_INCRIDX;
                    end else begin
                        value_d = valtotry;
                        state_d = ST_PASSFWD;
                    end
                end
            end
            ST_PASSFWD: begin
                state_d = ST_WAITING;
            end
            ST_PASSBAK: begin
                state_d = ST_WAITING;
                if (!locked_q) begin
                    value_d    = '0;
                    ring_clear = 1'b1;
                end
            end
            default: begin
                state_d = ST_RESET;
            end
        endcase

        // Outputs registered from the next state so they line up with it.
        passfwd_d  = (state_d == ST_PASSFWD);
        passbak_d  = (state_d == ST_PASSBAK);
        rq_valid_d = (state_d == ST_REQUEST);
        biasidx_d  = (state_d == ST_REQUEST) ? cand_next_c : '0;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= ST_RESET;
            value_q    <= '0;
            locked_q   <= 1'b0;
            trycount_q <= '0;
            passfwd_q  <= 1'b0;
            passbak_q  <= 1'b0;
            rq_valid_q <= 1'b0;
            biasidx_q  <= '0;
        end else begin
            state_q    <= state_d;
            value_q    <= value_d;
            locked_q   <= locked_d;
            trycount_q <= trycount_d;
            passfwd_q  <= passfwd_d;
            passbak_q  <= passbak_d;
            rq_valid_q <= rq_valid_d;
            biasidx_q  <= biasidx_d;
        end
    end

    assign passfwd  = passfwd_q;
    assign passbak  = passbak_q;
    assign rq_valid = rq_valid_q;
    assign biasidx  = biasidx_q;
    assign value    = value_q;
    assign locked   = locked_q;
    assign trycount = trycount_q;

endmodule

// File: tb/tb_tile_cell.sv
// Directed bench for tile_cell at GRID_ORDER=2 (LEN=4) with a scoreboard of
// expected output values.
module tb_tile_cell;
    import tile_pkg::*;

    localparam int unsigned LEN   = 4;
    localparam int unsigned TRY_W = 16;

    logic             clock = 1'b0;
    logic             reset;
    logic             myturn;
    logic             fromfwd;
    logic             passfwd;
    logic             passbak;
    logic             given_load;
    logic [LEN-1:0]   given_val;
    logic             rq_valid;
    logic             rq_ready;
    logic [LEN-1:0]   biasidx;
    logic             rsp_valid;
    logic [LEN-1:0]   valtotry;
    logic [LEN-1:0]   valcannotbe;
    logic [LEN-1:0]   value;
    logic             locked;
    logic [TRY_W-1:0] trycount;

    tile_cell #(
        .GRID_ORDER (2),
        .TRY_W      (TRY_W)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .myturn      (myturn),
        .fromfwd     (fromfwd),
        .passfwd     (passfwd),
        .passbak     (passbak),
        .given_load  (given_load),
        .given_val   (given_val),
        .rq_valid    (rq_valid),
        .rq_ready    (rq_ready),
        .biasidx     (biasidx),
        .rsp_valid   (rsp_valid),
        .valtotry    (valtotry),
        .valcannotbe (valcannotbe),
        .value       (value),
        .locked      (locked),
        .trycount    (trycount)
    );

    always #5 clock = ~clock;

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic expect_val(input string tag, input logic [31:0] v);
        sb.push_back('{tag, v});
    endtask

    task automatic observe(input logic [31:0] obs);
        exp_t e;
        if (sb.size() == 0) begin
            n_cmp++;
            n_err++;
            $error("FAIL sb_empty: observed %0h expected <none>", obs);
        end else begin
            e = sb.pop_front();
            check(e.tag, obs, e.val);
        end
    endtask

    // Advance one cycle, sample 1 time unit after the edge, check invariants.
    task automatic tick();
        @(posedge clock);
        #1;
        check("pass_excl", 32'(passfwd & passbak), 32'd0);
        check("bias_gate", 32'(rq_valid ? !is_onehot(64'(biasidx)) : (biasidx != '0)), 32'd0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        myturn = 1'b1;
        given_load = 1'b1;
        given_val = 4'b0001;
        expect_val("rst_value", 32'd0);
        expect_val("rst_locked", 32'd0);
        expect_val("rst_trycount", 32'd0);
        expect_val("rst_rq_valid", 32'd0);
        expect_val("rst_passfwd", 32'd0);
        expect_val("rst_passbak", 32'd0);
        tick();
        tick();
        observe(32'(value));
        observe(32'(locked));
        observe(32'(trycount));
        observe(32'(rq_valid));
        observe(32'(passfwd));
        observe(32'(passbak));
        reset = 1'b0;
        tick();   // RESET -> WAITING; myturn and given_load ignored in RESET
        myturn = 1'b0;
        given_load = 1'b0;
        given_val = '0;
        expect_val("post_rst_state", 32'(ST_WAITING));
        expect_val("post_rst_locked", 32'd0);
        observe(32'(dut.state_q));
        observe(32'(locked));
    endtask

    task automatic turn(input logic fwd);
        myturn = 1'b1;
        fromfwd = fwd;
        tick();
        myturn = 1'b0;
        fromfwd = 1'b0;
    endtask

    // Entered in INCRIDX with a candidate left; exits one cycle after the reply.
    task automatic serve(input logic [3:0] bias, input logic [3:0] reply, input logic [3:0] cannot);
        expect_val("req_valid", 32'd1);
        expect_val("req_bias", 32'(bias));
        tick();
        observe(32'(rq_valid));
        observe(32'(biasidx));
        rq_ready = 1'b1;
        expect_val("req_drop", 32'd0);
        tick();
        rq_ready = 1'b0;
        observe(32'(rq_valid));
        rsp_valid = 1'b1;
        valtotry = reply;
        valcannotbe = cannot;
        tick();
        rsp_valid = 1'b0;
        valtotry = '0;
        valcannotbe = '0;
    endtask

    task automatic expect_pass(input string tag, input logic fwd, input logic bak,
                               input logic [3:0] v, input int tc);
        expect_val({tag, "_passfwd"}, 32'(fwd));
        expect_val({tag, "_passbak"}, 32'(bak));
        expect_val({tag, "_value"}, 32'(v));
        expect_val({tag, "_trycount"}, 32'(tc));
        observe(32'(passfwd));
        observe(32'(passbak));
        observe(32'(value));
        observe(32'(trycount));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        myturn = 1'b0;
        fromfwd = 1'b0;
        given_load = 1'b0;
        given_val = '0;
        rq_ready = 1'b0;
        rsp_valid = 1'b0;
        valtotry = '0;
        valcannotbe = '0;

        // Fresh solve
        do_reset();
        turn(1'b0);
        serve(4'b0001, 4'b0010, 4'b0000);
        expect_pass("fresh", 1'b1, 1'b0, 4'b0010, 1);
        tick();
        expect_val("fresh_pulse_end", 32'd0);
        observe(32'(passfwd));

        // Exhaustion
        do_reset();
        turn(1'b0);
        serve(4'b0001, 4'b0001, 4'b1111);
        serve(4'b0010, 4'b0010, 4'b1111);
        serve(4'b0100, 4'b0100, 4'b1111);
        serve(4'b1000, 4'b1000, 4'b1111);
        tick();
        expect_pass("exhaust", 1'b0, 1'b1, 4'b0000, 4);
        tick();
        expect_val("exhaust_pulse_end", 32'd0);
        observe(32'(passbak));

        // Restart at bit 0, then stalls on both handshakes
        turn(1'b0);
        expect_val("restart_valid", 32'd1);
        expect_val("restart_bias", 32'b0001);
        tick();
        observe(32'(rq_valid));
        observe(32'(biasidx));
        for (int i = 0; i < 3; i++) begin
            expect_val("stall_valid", 32'd1);
            expect_val("stall_bias", 32'b0001);
            tick();
            observe(32'(rq_valid));
            observe(32'(biasidx));
        end
        rq_ready = 1'b1;
        tick();
        rq_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            expect_val("await_state", 32'(ST_AWAITRSP));
            expect_val("await_trycount", 32'd4);
            expect_val("await_rq", 32'd0);
            tick();
            observe(32'(dut.state_q));
            observe(32'(trycount));
            observe(32'(rq_valid));
        end
        rsp_valid = 1'b1;
        valtotry = 4'b1000;
        valcannotbe = 4'b0000;
        tick();
        rsp_valid = 1'b0;
        valtotry = '0;
        expect_pass("late_rsp", 1'b1, 1'b0, 4'b1000, 5);
        tick();
        rsp_valid = 1'b1;
        valtotry = 4'b0001;
        tick();
        rsp_valid = 1'b0;
        valtotry = '0;
        expect_pass("stray_rsp", 1'b0, 1'b0, 4'b1000, 5);

        // Clue cell
        given_load = 1'b1;
        given_val = 4'b0100;
        tick();
        given_load = 1'b0;
        given_val = '0;
        expect_val("clue_locked", 32'd1);
        expect_val("clue_value", 32'b0100);
        observe(32'(locked));
        observe(32'(value));
        turn(1'b0);
        expect_pass("clue_fwd", 1'b1, 1'b0, 4'b0100, 5);
        expect_val("clue_fwd_rq", 32'd0);
        observe(32'(rq_valid));
        tick();
        turn(1'b1);
        expect_pass("clue_bak", 1'b0, 1'b1, 4'b0100, 5);
        tick();
        given_load = 1'b1;
        given_val = 4'b0000;
        tick();
        given_load = 1'b0;
        expect_val("unclue_locked", 32'd0);
        expect_val("unclue_value", 32'd0);
        observe(32'(locked));
        observe(32'(value));

        // Resume on backtrack
        do_reset();
        turn(1'b0);
        serve(4'b0001, 4'b0001, 4'b0001);
        serve(4'b0010, 4'b0010, 4'b0001);
        expect_pass("resume_acc", 1'b1, 1'b0, 4'b0010, 2);
        tick();
        turn(1'b1);
        expect_val("resume_bias", 32'b0100);
        tick();
        observe(32'(biasidx));
        rq_ready = 1'b1;
        tick();
        rq_ready = 1'b0;

        // Mid-operation reset while awaiting the reply
        reset = 1'b1;
        tick();
        reset = 1'b0;
        expect_pass("midrst", 1'b0, 1'b0, 4'b0000, 0);
        expect_val("midrst_rq", 32'd0);
        expect_val("midrst_state", 32'(ST_RESET));
        observe(32'(rq_valid));
        observe(32'(dut.state_q));
        rsp_valid = 1'b1;
        valtotry = 4'b0001;
        tick();
        expect_val("midrst_wait", 32'(ST_WAITING));
        observe(32'(dut.state_q));
        tick();
        rsp_valid = 1'b0;
        valtotry = '0;
        expect_pass("midrst_late", 1'b0, 1'b0, 4'b0000, 0);
        turn(1'b0);
        expect_val("midrst_restart_bias", 32'b0001);
        tick();
        observe(32'(biasidx));

        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/tile_cell.md
Name: tile_cell

Overview:
- Parametrised brute-force Sudoku cell, the next generation of the per-cell solver.
- Cycles through candidate bias indices, requests a value from the shared bias module over a valid/ready handshake, and checks the reply against the external conflict mask.
- Passes control forward on success and backward on exhaustion.
- Adds clue-locked (given) cells and variable-latency bias replies, and exposes a saturating try counter for solver statistics.

Parameters:
- GRID_ORDER, 3, sub-grid side length. LEN = GRID_ORDER*GRID_ORDER values per row, 9 by default.
- TRY_W, 16, width of the trycount statistic counter.

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous, active-high.
- myturn  in  1  control token arrives. Sampled only in WAITING.
- fromfwd  in  1  qualifies myturn: 1 means the token is returning from the successor (backtrack), 0 means it comes from the predecessor.
- passfwd  out  1  one-cycle pulse: value accepted, hand the token forward.
- passbak  out  1  one-cycle pulse: candidates exhausted, or locked cell backtracking.
- given_load  in  1  load a clue. Accepted only in WAITING.
- given_val  in  LEN  clue value, one-hot. All-zero clears the clue.
- rq_valid  out  1  bias request valid.
- rq_ready  in  1  bias module accepts the request.
- biasidx  out  LEN  one-hot bias index. Nonzero only while rq_valid=1.
- rsp_valid  in  1  bias reply valid.
- valtotry  in  LEN  one-hot candidate. Qualified by rsp_valid.
- valcannotbe  in  LEN  mask of values used by peers. Sampled with rsp_valid.
- value  out  LEN  registered one-hot cell value. 0 means empty.
- locked  out  1  cell holds a clue.
- trycount  out  TRY_W  count of bias replies consumed. Saturating.

Behaviour:
- Reset (synchronous, every state): state=RESET; index = bit LEN set (empty); value=0; locked=0; trycount=0.
- Reset also forces passfwd, passbak, rq_valid and biasidx to 0. Any request or reply in flight is dropped.
- RESET always goes to WAITING after one cycle. myturn and given_load are ignored in RESET.
- index is LEN+1 bits, one-hot. Bit LEN means "exhausted/empty".
- States:
  - RESET, WAITING, INCRIDX, REQUEST, AWAITRSP, PASSFWD, PASSBAK.
- WAITING:
  - given_load=1 has priority over myturn.
  - given_load with given_val nonzero: value=given_val, locked=1.
  - given_load with given_val zero: value=0, locked=0, index=bit LEN.
  - Otherwise, myturn with locked=1: go to PASSBAK if fromfwd=1, else PASSFWD. value is unchanged in both cases.
  - Otherwise, myturn with locked=0: go to INCRIDX.
- INCRIDX: rotate index up by one, wrapping bit LEN to bit 0.
  - If the new index has bit LEN set, go to PASSBAK.
  - Otherwise go to REQUEST.
- REQUEST: rq_valid=1 and biasidx=index[LEN-1:0], both held stable until rq_ready=1, then go to AWAITRSP.
- AWAITRSP: wait indefinitely for rsp_valid. rsp_valid outside AWAITRSP is ignored. On rsp_valid:
  - trycount increments, saturating at all-ones.
  - If valtotry is zero or (valtotry & valcannotbe) is nonzero: go to INCRIDX, value unchanged.
  - Otherwise: value=valtotry, go to PASSFWD.
- PASSFWD: passfwd=1 for one cycle, then WAITING. index is retained, so a later backtrack resumes at the next index.
- PASSBAK: passbak=1 for one cycle, then WAITING.
  - If locked=0, value is cleared to 0 and index stays at bit LEN, so the next turn restarts at bit 0.
  - If locked=1, value is preserved.
- Latency, unlocked cell:
  - myturn sampled at cycle 0: INCRIDX at 1, REQUEST at 2 (handshake completes if rq_ready=1), AWAITRSP at 3.
  - With rsp_valid at cycle 3, passfwd is high at cycle 4.
- Latency, locked cell: passfwd or passbak is high at cycle 1.
- passfwd and passbak are never high together. Both are Moore outputs.

Decomposition:
- Package tile_pkg holds:
  - the state enum, one-hot encoded, 7 bits;
  - a function computing LEN from GRID_ORDER;
  - a one-hot validity check function used by the bench assertions.
- One sub-module, tile_index_ring, is natural. It holds the LEN+1 one-hot rotating register with ports clear/rotate/exhausted.
- The FSM, value, locked and trycount logic stay in tile_cell.

Test Plan:
All scenarios use GRID_ORDER=2 (LEN=4).
- Fresh solve: reset, myturn with rq_ready=1, rsp_valid at AWAITRSP, valtotry=0010, valcannotbe=0000 -> biasidx=0001 during REQUEST; passfwd pulse at cycle 4; value=0010; trycount=1.
- Exhaustion: valcannotbe=1111, replies echo biasidx -> four requests with biasidx 0001, 0010, 0100, 1000, then a passbak pulse; value=0000; trycount=4. The next myturn requests biasidx 0001 again.
- Stalls: rq_ready low for 3 cycles, then rsp_valid delayed 5 cycles -> rq_valid and biasidx=0001 held stable; no state change until each handshake completes; a stray rsp_valid in WAITING leaves trycount unchanged.
- Clue: given_load with given_val=0100 in WAITING -> value=0100, locked=1. Then myturn with fromfwd=0 gives a passfwd pulse at cycle 1 and no rq_valid. Then myturn with fromfwd=1 gives a passbak pulse with value still 0100.
- Resume on backtrack: accepted at biasidx 0010 (passfwd), then myturn with fromfwd=1 -> next request uses biasidx 0100.
- Mid-operation reset: reset asserted in AWAITRSP -> the next cycle has value=0, rq_valid=0, trycount=0, state WAITING one cycle later; a late rsp_valid is ignored.
